// File: rtl/clk_div_frac_prog.sv
// rtl/clk_div_frac_prog.sv - programmable half-integer clock divider, period = DIV2/2 clk cycles
// Optional ratio checking: define CLK_DIV_FRAC_CFG_CHECK_EN to reject ratios below 3 with cfg_err_o.
module clk_div_frac_prog #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_DIV2 = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_vld_i,
    input  logic [CNT_W-1:0] cfg_div2_i,
    output logic             cfg_rdy_o,
    output logic             cfg_err_o,
    output logic             clk_out,
    output logic             tick_o
);
    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} state_t;

    localparam logic [CNT_W-1:0] P_RST = CNT_W'(DEFAULT_DIV2);
    localparam logic [CNT_W-1:0] P_MIN = CNT_W'(3);
    localparam logic [CNT_W-1:0] C1    = CNT_W'(1);
    localparam logic [CNT_W:0]   X1    = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   X2    = (CNT_W+1)'(2);

    state_t           state;
    logic [CNT_W-1:0] p_act;
    logic [CNT_W-1:0] p_pend;
    logic [CNT_W-1:0] fcnt;
    logic             act;
    logic             q_p;
    logic             n_nxt;
    logic             q_n;

    logic             cfg_take;
    logic             cfg_bad;
    logic [CNT_W-1:0] cfg_val;

    logic             boundary;
    logic             act_nxt;
    logic             tick_nxt;
    logic             hi0;
    logic             hi1;
    logic             hi2;
    logic [CNT_W-1:0] p_nxt;
    logic [CNT_W-1:0] f_nxt;
    logic [CNT_W:0]   x0;

    // A frame is one period for even P and two periods (P clk cycles) for odd P.
    function automatic logic [CNT_W-1:0] frame_len(input logic [CNT_W-1:0] p);
        return p[0] ? p : (p >> 1);
    endfunction

    // Level of clk_out at half-cycle x of a frame.
    function automatic logic high_at(input logic [CNT_W-1:0] p, input logic [CNT_W:0] x);
        logic [CNT_W:0] pe;
        logic [CNT_W:0] c;
        pe = {1'b0, p};
        c  = (pe + X1) >> 1;
        return (x < c) || (p[0] && (x >= pe) && (x < pe + c));
    endfunction

    assign cfg_take = cfg_vld_i && cfg_rdy_o;

`ifdef CLK_DIV_FRAC_CFG_CHECK_EN
    assign cfg_bad = (cfg_div2_i < P_MIN);
    assign cfg_val = cfg_div2_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err_o <= 1'b0;
        end else begin
            cfg_err_o <= cfg_take && cfg_bad;
        end
    end
`else
    assign cfg_bad   = 1'b0;
    assign cfg_val   = (cfg_div2_i < P_MIN) ? P_MIN : cfg_div2_i;
    assign cfg_err_o = 1'b0;
`endif

    always_comb begin
        boundary = !act || (fcnt == frame_len(p_act) - C1);
        p_nxt    = (boundary && !cfg_rdy_o) ? p_pend : p_act;
        act_nxt  = boundary ? (state == ST_RUN) : 1'b1;
        f_nxt    = boundary ? '0 : fcnt + C1;
        x0       = {f_nxt, 1'b0};
        hi0      = high_at(p_nxt, x0);
        hi1      = high_at(p_nxt, x0 + X1);
        hi2      = high_at(p_nxt, x0 + X2);
        tick_nxt = act_nxt && ((f_nxt == '0) || (p_nxt[0] && ((x0 + X1) == {1'b0, p_nxt})));
    end

    // q_p covers the two half-cycles of this cycle; n_nxt is re-timed onto the
    // falling edge and covers the low half plus the next high half. High runs are
    // at least two half-cycles long, so OR-ing the pair reproduces the waveform.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_STOP;
            p_act     <= P_RST;
            p_pend    <= P_RST;
            fcnt      <= '0;
            act       <= 1'b0;
            q_p       <= 1'b0;
            n_nxt     <= 1'b0;
            tick_o    <= 1'b0;
            cfg_rdy_o <= 1'b1;
        end else begin
            act    <= act_nxt;
            fcnt   <= f_nxt;
            p_act  <= p_nxt;
            q_p    <= act_nxt && hi0 && hi1;
            n_nxt  <= act_nxt && hi1 && hi2;
            tick_o <= tick_nxt;

            if (boundary && !cfg_rdy_o) begin
                cfg_rdy_o <= 1'b1;
            end else if (cfg_take && !cfg_bad) begin
                p_pend    <= cfg_val;
                cfg_rdy_o <= 1'b0;
            end

            case (state)
                ST_STOP:  if (en) state <= ST_RUN;
                ST_RUN:   if (!en) state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (en) begin
                        state <= ST_RUN;
                    end else if (!act_nxt) begin
                        state <= ST_STOP;
                    end
                end
                default:  state <= ST_STOP;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            q_n <= 1'b0;
        end else begin
            q_n <= n_nxt;
        end
    end

    assign clk_out = q_p | q_n;

endmodule
